// File: rtl/v2f_load_store_unit.sv
// v2f_load_store_unit: turns byte-addressed byte/half/word load/store requests into single-port RAM accesses.
// Define V2F_LSU_BOOTLOAD_EN to add the post-reset BOOT state that strobes MEM_ARST for a RAM program reload.
module v2f_load_store_unit #(
  parameter int ABITS       = 2,
  parameter int SIZE        = 4,
  parameter int BOOT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_UNSIGNED,
  input  logic [ABITS+1:0] REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_RDATA,
  output logic             RSP_ERR,
  output logic             MEM_RD_EN,
  output logic [ABITS-1:0] MEM_RD_ADDR,
  input  logic [31:0]      MEM_RD_DATA,
  output logic             MEM_WR_EN,
  output logic [ABITS-1:0] MEM_WR_ADDR,
  output logic [31:0]      MEM_WR_DATA,
  output logic [3:0]       MEM_BYTE_SEL,
  output logic             MEM_ARST
);

  typedef enum logic [2:0] {
`ifdef V2F_LSU_BOOTLOAD_EN
    BOOT,
`endif
    IDLE,
    WRITE,
    READ,
    RDATA,
    RESP
  } state_t;

`ifdef V2F_LSU_BOOTLOAD_EN
  localparam state_t RST_STATE = BOOT;
  localparam int BCW = $clog2(BOOT_CYCLES + 1);
  logic [BCW-1:0] boot_cnt_r, boot_cnt_s;
  logic           mem_arst_r, mem_arst_s;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t           state_r, state_s;
  logic             req_ready_r, req_ready_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [31:0]      rsp_rdata_r, rsp_rdata_s;
  logic             rsp_err_r, rsp_err_s;
  logic             rd_en_r, rd_en_s;
  logic [ABITS-1:0] rd_addr_r, rd_addr_s;
  logic             wr_en_r, wr_en_s;
  logic [ABITS-1:0] wr_addr_r, wr_addr_s;
  logic [31:0]      wr_data_r, wr_data_s;
  logic [3:0]       byte_sel_r, byte_sel_s;
  logic [1:0]       size_r, size_s;
  logic             uns_r, uns_s;
  logic [1:0]       lane_r, lane_s;

  logic [ABITS-1:0] word_addr_s;
  logic             range_err_s;
  logic             req_err_s;
  logic [31:0]      st_data_s;
  logic [3:0]       st_sel_s;
  logic [31:0]      rd_lane_s;
  logic [31:0]      load_data_s;

  // Decode the incoming request: error check and lane-replicated store data/mask.
  always_comb begin
    word_addr_s = REQ_ADDR[ABITS+1:2];
    range_err_s = (32'(word_addr_s) >= 32'(SIZE));
    req_err_s   = 1'b1;
    st_data_s   = REQ_WDATA;
    st_sel_s    = 4'b1111;
    case (REQ_SIZE)
      2'd0: begin
        req_err_s = range_err_s;
        st_data_s = {4{REQ_WDATA[7:0]}};
        st_sel_s  = 4'b0001 << REQ_ADDR[1:0];
      end
      2'd1: begin
        req_err_s = range_err_s | REQ_ADDR[0];
        st_data_s = {2{REQ_WDATA[15:0]}};
        st_sel_s  = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        req_err_s = range_err_s | (|REQ_ADDR[1:0]);
        st_data_s = REQ_WDATA;
        st_sel_s  = 4'b1111;
      end
      default: begin
        req_err_s = 1'b1;
        st_data_s = REQ_WDATA;
        st_sel_s  = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the RAM word and extend it to 32 bits.
  always_comb begin
    rd_lane_s   = MEM_RD_DATA >> {lane_r, 3'b000};
    load_data_s = rd_lane_s;
    case (size_r)
      2'd0:    load_data_s = uns_r ? {24'h000000, rd_lane_s[7:0]}
                                   : {{24{rd_lane_s[7]}}, rd_lane_s[7:0]};
      2'd1:    load_data_s = uns_r ? {16'h0000, rd_lane_s[15:0]}
                                   : {{16{rd_lane_s[15]}}, rd_lane_s[15:0]};
      default: load_data_s = rd_lane_s;
    endcase
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_s     = state_r;
    req_ready_s = 1'b0;
    rsp_valid_s = rsp_valid_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    rd_en_s     = 1'b0;
    rd_addr_s   = rd_addr_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    byte_sel_s  = byte_sel_r;
    size_s      = size_r;
    uns_s       = uns_r;
    lane_s      = lane_r;
`ifdef V2F_LSU_BOOTLOAD_EN
    boot_cnt_s  = boot_cnt_r;
    mem_arst_s  = 1'b0;
`endif
    case (state_r)
`ifdef V2F_LSU_BOOTLOAD_EN
      BOOT: begin
        mem_arst_s = (boot_cnt_r == BCW'(0));
        if (boot_cnt_r == BCW'(BOOT_CYCLES - 1)) begin
          state_s     = IDLE;
          req_ready_s = 1'b1;
        end else begin
          boot_cnt_s = boot_cnt_r + BCW'(1);
        end
      end
`endif
      IDLE: begin
        if (REQ_VALID && req_ready_r) begin
          size_s = REQ_SIZE;
          uns_s  = REQ_UNSIGNED;
          lane_s = REQ_ADDR[1:0];
          if (req_err_s) begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
            rsp_rdata_s = 32'h00000000;
          end else if (REQ_WE) begin
            state_s    = WRITE;
            wr_en_s    = 1'b1;
            wr_addr_s  = word_addr_s;
            wr_data_s  = st_data_s;
            byte_sel_s = st_sel_s;
          end else begin
            state_s   = READ;
            rd_en_s   = 1'b1;
            rd_addr_s = word_addr_s;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      WRITE: begin
        state_s     = RESP;
        rsp_valid_s = 1'b1;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = 32'h00000000;
      end
      READ: begin
        state_s = RDATA;
      end
      RDATA: begin
        state_s     = RESP;
        rsp_valid_s = 1'b1;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = load_data_s;
      end
      RESP: begin
        if (RSP_READY) begin
          state_s     = IDLE;
          req_ready_s = 1'b1;
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = 32'h00000000;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r     <= RST_STATE;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h00000000;
      rsp_err_r   <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 32'h00000000;
      byte_sel_r  <= 4'b0000;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      lane_r      <= 2'd0;
`ifdef V2F_LSU_BOOTLOAD_EN
      boot_cnt_r  <= '0;
      mem_arst_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      rd_en_r     <= rd_en_s;
      rd_addr_r   <= rd_addr_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      byte_sel_r  <= byte_sel_s;
      size_r      <= size_s;
      uns_r       <= uns_s;
      lane_r      <= lane_s;
`ifdef V2F_LSU_BOOTLOAD_EN
      boot_cnt_r  <= boot_cnt_s;
      mem_arst_r  <= mem_arst_s;
`endif
    end
  end

  assign REQ_READY    = req_ready_r;
  assign RSP_VALID    = rsp_valid_r;
  assign RSP_RDATA    = rsp_rdata_r;
  assign RSP_ERR      = rsp_err_r;
  assign MEM_RD_EN    = rd_en_r;
  assign MEM_RD_ADDR  = rd_addr_r;
  assign MEM_WR_EN    = wr_en_r;
  assign MEM_WR_ADDR  = wr_addr_r;
  assign MEM_WR_DATA  = wr_data_r;
  assign MEM_BYTE_SEL = byte_sel_r;
`ifdef V2F_LSU_BOOTLOAD_EN
  assign MEM_ARST     = mem_arst_r;
`else
  assign MEM_ARST     = 1'b0;
`endif

endmodule

// File: tb/tb_v2f_load_store_unit.sv
// Directed bench for v2f_load_store_unit with a byte-masked RAM model; ABITS=3 so out-of-range addresses exist.
module tb_v2f_load_store_unit;
  localparam int ABITS = 3;
  localparam int SIZE  = 4;

  logic             CLK = 1'b0;
  logic             ARST_N = 1'b0;
  logic             REQ_VALID = 1'b0;
  logic             REQ_READY;
  logic             REQ_WE = 1'b0;
  logic [1:0]       REQ_SIZE = 2'd0;
  logic             REQ_UNSIGNED = 1'b0;
  logic [ABITS+1:0] REQ_ADDR = '0;
  logic [31:0]      REQ_WDATA = 32'h0;
  logic             RSP_VALID;
  logic             RSP_READY = 1'b0;
  logic [31:0]      RSP_RDATA;
  logic             RSP_ERR;
  logic             MEM_RD_EN;
  logic [ABITS-1:0] MEM_RD_ADDR;
  logic [31:0]      MEM_RD_DATA = 32'h0;
  logic             MEM_WR_EN;
  logic [ABITS-1:0] MEM_WR_ADDR;
  logic [31:0]      MEM_WR_DATA;
  logic [3:0]       MEM_BYTE_SEL;
  logic             MEM_ARST;

  int n_asserts = 0;
  int n_fail    = 0;

  int          r_lat, r_wr, r_rd;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_waddr, r_raddr;
  logic [31:0] hold_rdata;

  logic [31:0] ram [0:(1<<ABITS)-1];

  v2f_load_store_unit #(.ABITS(ABITS), .SIZE(SIZE), .BOOT_CYCLES(2)) dut (
    .CLK(CLK), .ARST_N(ARST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
    .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_RD_EN(MEM_RD_EN), .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_RD_DATA(MEM_RD_DATA),
    .MEM_WR_EN(MEM_WR_EN), .MEM_WR_ADDR(MEM_WR_ADDR), .MEM_WR_DATA(MEM_WR_DATA),
    .MEM_BYTE_SEL(MEM_BYTE_SEL), .MEM_ARST(MEM_ARST)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM model: registered read, byte-masked write.
  always @(posedge CLK) begin
    if (MEM_RD_EN) MEM_RD_DATA <= ram[MEM_RD_ADDR];
    if (MEM_WR_EN) begin
      for (int b = 0; b < 4; b++)
        if (MEM_BYTE_SEL[b]) ram[MEM_WR_ADDR][8*b +: 8] <= MEM_WR_DATA[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {22'h0, REQ_READY, RSP_VALID, RSP_ERR, MEM_RD_EN, MEM_WR_EN, MEM_ARST, MEM_BYTE_SEL}, 32'h0);
    chk({tag, "_rdata"}, RSP_RDATA, 32'h0);
    chk({tag, "_wdata"}, MEM_WR_DATA, 32'h0);
    chk({tag, "_addr"}, {26'h0, MEM_RD_ADDR, MEM_WR_ADDR}, 32'h0);
  endtask

  task automatic after_release();
    @(negedge CLK);
    ARST_N = 1'b1;
    @(posedge CLK); #1;
`ifdef V2F_LSU_BOOTLOAD_EN
    chk("boot_arst_hi", {31'h0, MEM_ARST}, 32'h1);
    chk("boot_ready_lo", {31'h0, REQ_READY}, 32'h0);
    @(posedge CLK); #1;
    chk("boot_arst_lo", {31'h0, MEM_ARST}, 32'h0);
    chk("boot_ready_hi", {31'h0, REQ_READY}, 32'h1);
`else
    chk("rel_ready", {31'h0, REQ_READY}, 32'h1);
    chk("rel_arst", {31'h0, MEM_ARST}, 32'h0);
`endif
  endtask

  // Issue one request, scramble inputs after accept, watch the memory port until RSP_VALID.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [ABITS+1:0] addr, input logic [31:0] wd);
    int k;
    k = 0;
    @(negedge CLK);
    while (!REQ_READY && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("req_ready", {31'h0, REQ_READY}, 32'h1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns; REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = ~we; REQ_SIZE = ~sz; REQ_UNSIGNED = ~uns; REQ_ADDR = ~addr; REQ_WDATA = ~wd;
    r_lat = 0; r_wr = 0; r_rd = 0;
    r_sel = 4'h0; r_wdata = 32'h0; r_waddr = 32'hFFFFFFFF; r_raddr = 32'hFFFFFFFF;
    do begin
      @(negedge CLK);
      r_lat++;
      if (MEM_WR_EN) begin
        r_wr++; r_sel = MEM_BYTE_SEL; r_wdata = MEM_WR_DATA; r_waddr = 32'(MEM_WR_ADDR);
      end
      if (MEM_RD_EN) begin
        r_rd++; r_raddr = 32'(MEM_RD_ADDR);
      end
    end while (!RSP_VALID && r_lat < 10);
    chk("rsp_valid_seen", {31'h0, RSP_VALID}, 32'h1);
  endtask

  task automatic consume();
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic exp_store(input string tag, input logic [3:0] sel, input logic [31:0] data, input logic [31:0] waddr);
    chk({tag, "_lat"}, 32'(r_lat), 32'd2);
    chk({tag, "_wr_cnt"}, 32'(r_wr), 32'd1);
    chk({tag, "_rd_cnt"}, 32'(r_rd), 32'd0);
    chk({tag, "_sel"}, {28'h0, r_sel}, {28'h0, sel});
    chk({tag, "_wdata"}, r_wdata, data);
    chk({tag, "_waddr"}, r_waddr, waddr);
    chk({tag, "_rsp"}, {RSP_ERR, RSP_RDATA[30:0]} | {31'h0, |RSP_RDATA}, 32'h0);
  endtask

  task automatic exp_load(input string tag, input logic [31:0] raddr, input logic [31:0] data);
    chk({tag, "_lat"}, 32'(r_lat), 32'd3);
    chk({tag, "_rd_cnt"}, 32'(r_rd), 32'd1);
    chk({tag, "_wr_cnt"}, 32'(r_wr), 32'd0);
    chk({tag, "_raddr"}, r_raddr, raddr);
    chk({tag, "_rdata"}, RSP_RDATA, data);
    chk({tag, "_err"}, {31'h0, RSP_ERR}, 32'h0);
  endtask

  task automatic exp_err(input string tag);
    chk({tag, "_lat"}, 32'(r_lat), 32'd1);
    chk({tag, "_no_mem"}, 32'(r_rd + r_wr), 32'd0);
    chk({tag, "_err"}, {31'h0, RSP_ERR}, 32'h1);
    chk({tag, "_rdata"}, RSP_RDATA, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ABITS); i++) ram[i] = 32'h0;

    // Reset state
    #2;
    chk_all_zero("reset");
    after_release();

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 5'h04, 32'hDEADBEEF);
    exp_store("st_word", 4'b1111, 32'hDEADBEEF, 32'd1);
    consume();
    do_req(1'b0, 2'd2, 1'b0, 5'h04, 32'h0);
    exp_load("ld_word", 32'd1, 32'hDEADBEEF);
    consume();

    // Byte store, signed and unsigned byte loads
    do_req(1'b1, 2'd0, 1'b0, 5'h06, 32'h123456A5);
    exp_store("st_byte", 4'b0100, 32'hA5A5A5A5, 32'd1);
    consume();
    do_req(1'b0, 2'd0, 1'b0, 5'h06, 32'h0);
    exp_load("ld_byte_s", 32'd1, 32'hFFFFFFA5);
    consume();
    do_req(1'b0, 2'd0, 1'b1, 5'h06, 32'h0);
    exp_load("ld_byte_u", 32'd1, 32'h000000A5);
    consume();

    // Half store into upper half of word 0, loads
    do_req(1'b1, 2'd2, 1'b0, 5'h00, 32'h11223344);
    exp_store("st_w0", 4'b1111, 32'h11223344, 32'd0);
    consume();
    do_req(1'b1, 2'd1, 1'b0, 5'h02, 32'hCAFE8001);
    exp_store("st_half", 4'b1100, 32'h80018001, 32'd0);
    consume();
    do_req(1'b0, 2'd1, 1'b0, 5'h02, 32'h0);
    exp_load("ld_half_s", 32'd0, 32'hFFFF8001);
    consume();
    do_req(1'b0, 2'd1, 1'b1, 5'h02, 32'h0);
    exp_load("ld_half_u", 32'd0, 32'h00008001);
    consume();
    do_req(1'b0, 2'd2, 1'b0, 5'h00, 32'h0);
    exp_load("ld_w0", 32'd0, 32'h80013344);
    consume();

    // Error cases
    do_req(1'b0, 2'd2, 1'b0, 5'h01, 32'h0);
    exp_err("err_word_mis");
    consume();
    do_req(1'b0, 2'd1, 1'b0, 5'h03, 32'h0);
    exp_err("err_half_mis");
    consume();
    do_req(1'b0, 2'd3, 1'b0, 5'h00, 32'h0);
    exp_err("err_size3");
    consume();
    do_req(1'b0, 2'd2, 1'b0, 5'h10, 32'h0);
    exp_err("err_range_ld");
    consume();
    do_req(1'b1, 2'd0, 1'b0, 5'h11, 32'h000000FF);
    exp_err("err_range_st");
    consume();

    // Response held under backpressure
    do_req(1'b0, 2'd2, 1'b0, 5'h04, 32'h0);
    exp_load("ld_bp", 32'd1, 32'hDEA5BEEF);
    hold_rdata = RSP_RDATA;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("bp_valid", {31'h0, RSP_VALID}, 32'h1);
      chk("bp_rdata", RSP_RDATA, hold_rdata);
      chk("bp_ready", {31'h0, REQ_READY}, 32'h0);
    end
    consume();
    chk("post_hs_valid", {31'h0, RSP_VALID}, 32'h0);
    chk("post_hs_ready", {31'h0, REQ_READY}, 32'h1);

    // Asynchronous reset while a read is in flight
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'd2; REQ_ADDR = 5'h04;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("mid_rd_en", {31'h0, MEM_RD_EN}, 32'h1);
    @(negedge CLK);
    ARST_N = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    after_release();
    do_req(1'b0, 2'd2, 1'b0, 5'h04, 32'h0);
    exp_load("ld_after_rst", 32'd1, 32'hDEA5BEEF);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
